reg_file_scb: RTL

- Parametrised register file: configurable data width, depth and read-port count; one write port.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register busy scoreboard, so the pipelined CPU's hazard logic can tell when a register still has a write pending.
- Storage is not reset; a post-reset sweep zeroes it, so the array can map onto RAM/MLAB.

---
 rtl/reg_file_scb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/reg_file_scb.sv
// Parametrised register file with N combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired-zero r0 and a per-register
// busy scoreboard. Storage has no reset; a post-reset sweep zeroes it so the
// array can map onto RAM.
module reg_file_scb #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NUM_RD  = 2,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       ready,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic [(1<<ADDR_W)-1:0]     busy_vec
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ready_q;
  logic [DEPTH-1:0]    busy_q;
  logic [DEPTH-1:0]    busy_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Architectural write, only once the sweep is finished; r0 writes dropped when hardwired
  logic                arch_we;
  assign arch_we = ready_q && wr_en && !(ZERO_R0 && (wr_addr == '0));

  // Init sweep FSM: walk the counter over every register, then park in READY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end
        end
        S_READY: begin
          state_q <= S_READY;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  // Single storage write port shared by the sweep and architectural writes
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!ready_q) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (arch_we) begin
      mem_we    = 1'b1;
    end
  end

  // Storage array, intentionally without reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Scoreboard next state: a write clears, a same-cycle issue wins and sets
  always_comb begin
    busy_d = busy_q;
    if (ready_q) begin
      if (wr_en) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (iss_en) begin
        busy_d[iss_addr] = 1'b1;
      end
    end
    if (ZERO_R0) begin
      busy_d[0] = 1'b0;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign ready    = ready_q;
  assign busy_vec = busy_q;

  // Independent combinational read ports with bypass and zero-register handling
  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_zero;
    logic              hit;

    assign a       = rd_addr[i*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_R0 && (a == '0);
    assign hit     = BYPASS && wr_en && (wr_addr == a);

    assign rd_data[i*DATA_W +: DATA_W] = (!ready_q || is_zero) ? '0 :
                                         hit                   ? wr_data :
                                                                 mem[a];
    assign rd_busy[i] = ready_q && !is_zero && busy_q[a] && !hit;
  end

endmodule
